// File: rtl/binary_search_controller.sv
// binary_search_controller: sequencing FSM for the binary search datapath/ROM.
// Drives one datapath strobe at a time, waits out the ROM read latency before
// each fetch and reports completion through a busy/done level handshake.
// Optional build macro BSA_PROBE_COUNT_EN adds the probe_count output.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start, all strobes low
// LOAD    | init strobe: datapath loads A, left=0, right=max, addr=mid
// READ    | waiting ROM_LATENCY cycles for data_out to settle
// FETCH   | update_arr_data: capture data_out
// COMPARE | classify equal / greater_than, remember direction
// ADJUST  | update_left or update_right according to direction
// CHECK   | continue_search ? update_addr and re-read : give up
// HIT     | value_found strobe
// MISS    | value_not_found strobe
// DONE    | done high until start drops
module binary_search_controller #(
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic equal,
  input  logic greater_than,
  input  logic continue_search,
  output logic init,
  output logic update_arr_data,
  output logic update_left,
  output logic update_right,
  output logic update_addr,
  output logic value_found,
  output logic value_not_found,
  output logic busy,
`ifdef BSA_PROBE_COUNT_EN
  output logic [$clog2(ADDR_WIDTH+2)-1:0] probe_count,
`endif
  output logic done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_FETCH,
    S_COMPARE,
    S_ADJUST,
    S_CHECK,
    S_HIT,
    S_MISS,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ROM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // Set means the last compare found A above the probe, so the left bound moves.
  logic       dir_left_q, dir_left_d;

  // State, wait counter and direction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      dir_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dir_left_q <= dir_left_d;
    end
  end

  // Next-state and strobe decode; update_addr is Mealy on continue_search.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    dir_left_d      = dir_left_q;
    init            = 1'b0;
    update_arr_data = 1'b0;
    update_left     = 1'b0;
    update_right    = 1'b0;
    update_addr     = 1'b0;
    value_found     = 1'b0;
    value_not_found = 1'b0;
    busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    done            = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        init       = 1'b1;
        wait_cnt_d = WAIT_INIT;
        state_d    = S_READ;
      end
      S_READ: begin
        if (wait_cnt_q == 4'd0) state_d = S_FETCH;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_FETCH: begin
        update_arr_data = 1'b1;
        state_d         = S_COMPARE;
      end
      S_COMPARE: begin
        if (equal) begin
          state_d = S_HIT;
        end else begin
          dir_left_d = greater_than;
          state_d    = S_ADJUST;
        end
      end
      S_ADJUST: begin
        if (dir_left_q) update_left  = 1'b1;
        else            update_right = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (continue_search) begin
          update_addr = 1'b1;
          wait_cnt_d  = WAIT_INIT;
          state_d     = S_READ;
        end else begin
          state_d = S_MISS;
        end
      end
      S_HIT: begin
        value_found = 1'b1;
        state_d     = S_DONE;
      end
      S_MISS: begin
        value_not_found = 1'b1;
        state_d         = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BSA_PROBE_COUNT_EN
  localparam int PCW = $clog2(ADDR_WIDTH + 2);

  logic [PCW-1:0] probe_count_q, probe_count_d;

  // Probe counter: cleared by LOAD, bumped per FETCH, held otherwise.
  always_comb begin
    probe_count_d = probe_count_q;
    if (state_q == S_LOAD)       probe_count_d = '0;
    else if (state_q == S_FETCH) probe_count_d = probe_count_q + PCW'(1);
  end

  // Probe counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) probe_count_q <= '0;
    else          probe_count_q <= probe_count_d;
  end

  assign probe_count = probe_count_q;
`endif

endmodule

// File: tb/tb_binary_search_controller.sv
// Bench for binary_search_controller: behavioural datapath + 32-entry ROM
// (entry[i] = 2i, one-cycle read latency) around the controller, with a
// scoreboard of expected completion latency and datapath result per search.
module tb_binary_search_controller;

  localparam int AW = 5;

  logic clk;
  logic reset_n;
  logic start;
  logic equal, greater_than, continue_search;
  logic init, update_arr_data, update_left, update_right, update_addr;
  logic value_found, value_not_found, busy, done;
`ifdef BSA_PROBE_COUNT_EN
  logic [$clog2(AW+2)-1:0] probe_count;
`endif

  binary_search_controller #(.ROM_LATENCY(1), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .equal           (equal),
    .greater_than    (greater_than),
    .continue_search (continue_search),
    .init            (init),
    .update_arr_data (update_arr_data),
    .update_left     (update_left),
    .update_right    (update_right),
    .update_addr     (update_addr),
    .value_found     (value_found),
    .value_not_found (value_not_found),
    .busy            (busy),
`ifdef BSA_PROBE_COUNT_EN
    .probe_count     (probe_count),
`endif
    .done            (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath + ROM model ----------------
  logic [7:0]        a_in;
  logic [7:0]        a_reg, arr_data, data_out;
  logic signed [6:0] left_s, right_s;
  logic [AW-1:0]     addr, l_reg;
  logic              found, not_found;
  logic [6:0]        mid_sum;

  assign equal           = (arr_data == a_reg);
  assign greater_than    = (a_reg > arr_data);
  assign continue_search = (left_s <= right_s);
  assign mid_sum         = left_s + right_s;

  always @(posedge clk) begin
    data_out <= {2'b00, addr, 1'b0};
    if (init) begin
      a_reg     <= a_in;
      left_s    <= 7'sd0;
      right_s   <= 7'sd31;
      addr      <= 5'd15;
      found     <= 1'b0;
      not_found <= 1'b0;
      l_reg     <= '0;
    end else begin
      if (update_arr_data) arr_data <= data_out;
      if (update_left)     left_s   <= $signed({2'b00, addr}) + 7'sd1;
      if (update_right)    right_s  <= $signed({2'b00, addr}) - 7'sd1;
      if (update_addr)     addr     <= mid_sum[5:1];
      if (value_found) begin
        found <= 1'b1;
        l_reg <= addr;
      end
      if (value_not_found) not_found <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobe_cnt();
    return 32'(init) + 32'(update_arr_data) + 32'(update_left) + 32'(update_right)
         + 32'(update_addr) + 32'(value_found) + 32'(value_not_found);
  endfunction

  // At most one strobe per cycle, and busy/done never together.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("strobe_onehot", 32'(strobe_cnt() <= 1), 32'd1);
      chk("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  typedef struct {
    int cycles;
    int l;
    int f;
    int nf;
    int pc;
  } exp_t;

  exp_t sb[$];

  task automatic run_search(input int a, input int cyc_exp, input int l, input int f,
                            input int nf, input int pc, input bit keep_start);
    exp_t e;
    int   t0;
    bit   got;
    int   elapsed;
    e = '{cyc_exp, l, f, nf, pc};
    sb.push_back(e);
    @(negedge clk);
    a_in  = 8'(a);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!keep_start) start = 1'b0;
    got = 1'b0;
    elapsed = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        elapsed = cyc - t0;
      end
    end
    chk($sformatf("done_seen_A%0d", a), 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk($sformatf("done_latency_A%0d", a), 32'(elapsed), 32'(e.cycles));
      chk($sformatf("found_A%0d", a), 32'(found), 32'(e.f));
      chk($sformatf("not_found_A%0d", a), 32'(not_found), 32'(e.nf));
      if (e.f == 1) chk($sformatf("L_A%0d", a), 32'(l_reg), 32'(e.l));
`ifdef BSA_PROBE_COUNT_EN
      chk($sformatf("probe_count_A%0d", a), 32'(probe_count), 32'(e.pc));
`endif
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_strobes"}, strobe_cnt(), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef BSA_PROBE_COUNT_EN
    chk({tag, "_probe_count"}, 32'(probe_count), 32'd0);
`endif
  endtask

  initial begin
    bit hit_adjust;
    reset_n = 1'b0;
    start   = 1'b0;
    a_in    = 8'd0;
    repeat (3) @(negedge clk);
    chk_all_low("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // One probe, hit at 15.
    run_search(30, 5, 15, 1, 0, 1, 1'b0);
    // Six probes climbing to the top entry.
    run_search(62, 30, 31, 1, 0, 6, 1'b0);
    // Five probes down to entry 0.
    run_search(0, 25, 0, 1, 0, 5, 1'b0);
    // Odd value: right drops below left after five probes.
    run_search(31, 27, 0, 0, 1, 5, 1'b0);

    // start held high through DONE: no restart.
    run_search(30, 5, 15, 1, 0, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_strobes", strobe_cnt(), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("release_done", 32'(done), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    run_search(2, 20, 1, 1, 0, 4, 1'b0);

    // Asynchronous reset during ADJUST of an A=62 search.
    @(negedge clk);
    a_in  = 8'd62;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit_adjust = 1'b0;
    for (int i = 0; i < 50 && !hit_adjust; i++) begin
      @(negedge clk);
      if ((update_left | update_right) === 1'b1) hit_adjust = 1'b1;
    end
    chk("adjust_reached", 32'(hit_adjust), 32'd1);
    chk("adjust_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_low("async_reset");
    repeat (2) @(negedge clk);
    chk_all_low("reset_hold");
    reset_n = 1'b1;
    run_search(30, 5, 15, 1, 0, 1, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
